// File: rtl/serial_pkg.sv
// serial_pkg
//   Definitions shared by the serial link blocks: receiver FSM state
//   encodings, default payload width, the idle line level and a helper
//   that gives the total frame length (start + data + stop).
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int unsigned DEFAULT_DATA_BITS = 8;

    // Level of an idle line and of a valid stop bit; shared with the transmitter.
    localparam logic LINE_IDLE = 1'b1;

    // Frame length in bit periods: one start bit, the payload, one stop bit.
    function automatic int unsigned frame_bits(input int unsigned data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/serial_frame_rx_sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a single asynchronous input.
//   Ports:
//     clk  in  1  destination clock
//     rst  in  1  asynchronous active-high reset
//     d    in  1  asynchronous input
//     q    out 1  synchronised copy of d (2-cycle latency)
//   RESET_VAL sets the value both flops take in reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   8N1 serial frame receiver. Oversamples the one-wire link, deserialises
//   LSB first and hands each good byte to the CPU through a valid/ack
//   holding register. Reports framing errors and overruns as pulses.
//   Ports:
//     clk                in  1          system clock
//     rst                in  1          asynchronous active-high reset
//     ser_data_in        in  1          asynchronous serial line, idles high
//     char_ack           in  1          CPU consumed parallel_data_out
//     parallel_data_out  out DATA_BITS  last good byte
//     data_valid         out 1          holding register holds an unacked byte
//     char_received      out 1          pulse: good byte loaded
//     frame_err          out 1          pulse: stop bit sampled low
//     overrun            out 1          pulse: good byte replaced an unacked one
//     busy               out 1          FSM not in IDLE
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_data_in,
    input  logic                 char_ack,
    output logic [DATA_BITS-1:0] parallel_data_out,
    output logic                 data_valid,
    output logic                 char_received,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
    localparam int unsigned FRAME_LEN = frame_bits(DATA_BITS);
    localparam int unsigned PW        = $clog2(FRAME_LEN);

    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] LAST_DATA   = PW'(FRAME_LEN - 2);

    logic                 rxs;
    rx_state_t            state;
    logic [CW-1:0]        bit_cnt;
    logic [PW-1:0]        bit_pos;   // frame position being timed: 0 = start, 1..DATA_BITS = payload
    logic [DATA_BITS-1:0] shreg;
    logic                 done_good;
    logic                 done_bad;

    sync_2ff #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ser_data_in),
        .q   (rxs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            busy              <= 1'b0;
            bit_cnt           <= '0;
            bit_pos           <= '0;
            shreg             <= '0;
            done_good         <= 1'b0;
            done_bad          <= 1'b0;
            parallel_data_out <= '0;
            data_valid        <= 1'b0;
            char_received     <= 1'b0;
            frame_err         <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            char_received <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
            done_good     <= 1'b0;
            done_bad      <= 1'b0;

            // Stop-bit verdict is acted on one cycle after the sample, in
            // parallel with the FSM, so IDLE can already accept the next
            // start bit while the byte is being loaded. A load takes
            // priority over a same-cycle ack.
            if (done_good) begin
                parallel_data_out <= shreg;
                char_received     <= 1'b1;
                data_valid        <= 1'b1;
                overrun           <= data_valid & ~char_ack;
            end else begin
                if (char_ack) begin
                    data_valid <= 1'b0;
                end
                if (done_bad) begin
                    frame_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (rxs != LINE_IDLE) begin
                        state   <= START;
                        busy    <= 1'b1;
                        bit_cnt <= HALF_RELOAD;
                        bit_pos <= '0;
                    end
                end

                START: begin
                    if (bit_cnt == '0) begin
                        if (rxs == LINE_IDLE) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= FULL_RELOAD;
                            bit_pos <= bit_pos + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end

                DATA: begin
                    if (bit_cnt == '0) begin
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt <= FULL_RELOAD;
                        bit_pos <= bit_pos + 1'b1;
                        if (bit_pos == LAST_DATA) begin
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end

                STOP: begin
                    if (bit_cnt == '0) begin
                        if (rxs == LINE_IDLE) begin
                            done_good <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            done_bad <= 1'b1;
                            state    <= WAIT_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    // A held-low (break) line must return high before a new frame.
                    if (rxs == LINE_IDLE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
//   Directed stimulus for serial_frame_rx with a scoreboard: each frame sent
//   pushes its expected outcome, and a negedge monitor pops and compares
//   whenever the receiver emits char_received, frame_err or overrun.
module tb_serial_frame_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
    // Pin falling edge at a negedge N0 -> result pulse visible at negedge N0+156
    localparam time LAT = 156 * 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          ser_data_in;
    logic          char_ack;
    logic [DB-1:0] parallel_data_out;
    logic          data_valid;
    logic          char_received;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    always #5 clk = ~clk;

    serial_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ser_data_in       (ser_data_in),
        .char_ack          (char_ack),
        .parallel_data_out (parallel_data_out),
        .data_valid        (data_valid),
        .char_received     (char_received),
        .frame_err         (frame_err),
        .overrun           (overrun),
        .busy              (busy)
    );

    typedef struct {
        bit            is_err;
        logic [DB-1:0] data;
        bit            ovr;
        bit            dv;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    time  t_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && (char_received || frame_err || overrun)) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: cr=%0b fe=%0b ov=%0b data=%02h, expected no event (t=%0t)",
                         char_received, frame_err, overrun, parallel_data_out, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_latency", 32'($time - t_fall), 32'(LAT));
                check("char_received", {31'd0, char_received}, {31'd0, !e.is_err});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
                check("overrun", {31'd0, overrun}, {31'd0, e.ovr});
                check("data_out", {24'd0, parallel_data_out}, {24'd0, e.data});
                check("data_valid_evt", {31'd0, data_valid}, {31'd0, e.dv});
            end
        end
    end

    task automatic push_good(input logic [DB-1:0] d, input bit ovr);
        exp_t e;
        e.is_err = 1'b0; e.data = d; e.ovr = ovr; e.dv = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [DB-1:0] held, input bit dv);
        exp_t e;
        e.is_err = 1'b1; e.data = held; e.ovr = 1'b0; e.dv = dv;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the stop bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        ser_data_in = 1'b0;
        t_fall = $time;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            ser_data_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        ser_data_in = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        char_ack = 1'b1;
        @(negedge clk);
        char_ack = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d events outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        ser_data_in = 1'b1;
        char_ack    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, parallel_data_out}, 32'h0);
        check("rst_dv", {31'd0, data_valid}, 32'd0);
        check("rst_cr", {31'd0, char_received}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        check("rst_ov", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(4);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 1: good frame 0xA5, hold until ack, then ignored ack
        push_good(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1);
        drain();
        check("t1_data", {24'd0, parallel_data_out}, 32'hA5);
        idle(10);
        check("t1_dv_hold", {31'd0, data_valid}, 32'd1);
        ack();
        check("t1_dv_acked", {31'd0, data_valid}, 32'd0);
        ack();
        check("t1_dv_stray_ack", {31'd0, data_valid}, 32'd0);
        check("t1_data_after_ack", {24'd0, parallel_data_out}, 32'hA5);

        // 2: 5-cycle glitch low -> false start
        ser_data_in = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_busy_start", {31'd0, busy}, 32'd1);
        ser_data_in = 1'b1;
        repeat (7) @(negedge clk);
        check("t2_busy_drop", {31'd0, busy}, 32'd0);
        check("t2_data", {24'd0, parallel_data_out}, 32'hA5);
        check("t2_dv", {31'd0, data_valid}, 32'd0);
        idle(20);

        // 3: bad stop bit, break held low, then good 0x81
        push_err(8'hA5, 1'b0);
        push_good(8'h81, 1'b0);
        send_frame(8'h3C, 1'b0);
        idle(40);
        check("t3_data_kept", {24'd0, parallel_data_out}, 32'hA5);
        check("t3_busy_break", {31'd0, busy}, 32'd1);
        ser_data_in = 1'b1;
        idle(16);
        check("t3_busy_released", {31'd0, busy}, 32'd0);
        send_frame(8'h81, 1'b1);
        drain();
        check("t3_data", {24'd0, parallel_data_out}, 32'h81);
        ack();

        // 4: back-to-back without ack -> overrun
        push_good(8'h11, 1'b0);
        push_good(8'h22, 1'b1);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        drain();
        check("t4_data", {24'd0, parallel_data_out}, 32'h22);
        check("t4_dv", {31'd0, data_valid}, 32'd1);
        ack();

        // 5: ack coincides with load of 0x33 -> load wins, no overrun
        push_good(8'h44, 1'b0);
        send_frame(8'h44, 1'b1);
        drain();
        push_good(8'h33, 1'b0);
        fork
            send_frame(8'h33, 1'b1);
            begin
                repeat (155) @(negedge clk);
                char_ack = 1'b1;
                @(negedge clk);
                char_ack = 1'b0;
            end
        join
        drain();
        check("t5_data", {24'd0, parallel_data_out}, 32'h33);
        check("t5_dv", {31'd0, data_valid}, 32'd1);

        // 6: reset after bit 3 of 0x5A, then a clean 0x5A
        ser_data_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ser_data_in = (i % 2 == 1) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b1;
        ser_data_in = 1'b1;
        @(negedge clk);
        check("t6_rst_data", {24'd0, parallel_data_out}, 32'h0);
        check("t6_rst_dv", {31'd0, data_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_pulses", {29'd0, char_received, frame_err, overrun}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(30);
        check("t6_post_busy", {31'd0, busy}, 32'd0);
        check("t6_post_dv", {31'd0, data_valid}, 32'd0);
        push_good(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b1);
        drain();
        check("t6_data", {24'd0, parallel_data_out}, 32'h5A);
        check("t6_dv", {31'd0, data_valid}, 32'd1);

        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
